mcu_spi_mux: RTL and testbench
==============================

MCU_SPI_MUX -- requirements
Module: mcu_spi_mux

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of MCU SPI sources, legal 2..4.
REQ-002 SHALL have parameter DEFAULT_PORT, default 0: port selected after reset.
REQ-003 SHALL have parameter STICKY, default 1: 1 = once switched away from DEFAULT_PORT, no further switching; 0 = takeover by any port plus idle revert.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 32000000: idle cycles before revert when STICKY=0, legal >= 2.
REQ-005 SHALL have parameter SYNC_STAGES, default 2: csn synchronizer depth, legal 2..3.
REQ-006 clk32  input  1  system clock; all logic on its rising edge.
REQ-007 por  input  1  reset, synchronous, active-high.
REQ-008 port_sclk  input  NUM_PORTS  per-port SPI clock from MCU.
REQ-009 port_csn  input  NUM_PORTS  per-port active-low select from MCU.
REQ-010 port_mosi  input  NUM_PORTS  per-port data from MCU.
REQ-011 port_miso  output  NUM_PORTS  data to MCUs.
REQ-012 port_intn  output  NUM_PORTS  active-low interrupt to MCUs.
REQ-013 mcu_sclk, mcu_csn, mcu_mosi  output  1 each  muxed SPI to core.
REQ-014 mcu_miso, mcu_intn  input  1 each  SPI data and interrupt from core.
REQ-015 active_port  output  2  registered index of selected port.
REQ-016 switched  output  1  one-cycle pulse when active_port changes.

Function
REQ-017 port_csn SHALL pass through SYNC_STAGES flops per port; synced value and its previous-cycle copy feed all control decisions.
REQ-018 mcu_sclk/mcu_mosi SHALL be combinational mux of raw port inputs selected by active_port.
REQ-019 mcu_csn SHALL equal raw port_csn[active_port] in ACTIVE, forced 1 in BLOCK.
REQ-020 port_miso[i] and port_intn[i] SHALL equal mcu_miso and mcu_intn for all i (broadcast, ungated).
REQ-021 Request: synced csn falling edge (1 then 0) on port i != active_port; latched in one-hot pending register until serviced or reset.
REQ-022 Requests SHALL be ignored when STICKY=1 and active_port != DEFAULT_PORT.
REQ-023 Simultaneous pending requests: lowest index wins; others cleared when switch commits.
REQ-024 States: ACTIVE, BLOCK; one-hot or binary is implementer's choice.
REQ-025 ACTIVE -> BLOCK when any request pending and synced csn of active port is 1; same edge: active_port <= winner, switched = 1, pending cleared.
REQ-026 While active port synced csn = 0, switch SHALL wait (pending held); active transaction never truncated.
REQ-027 BLOCK -> ACTIVE when synced csn of new active_port = 1; requester's first transaction thus discarded.
REQ-028 STICKY=0: idle counter counts cycles of ACTIVE with active_port != DEFAULT_PORT and synced csn = 1; reset on csn = 0, on switch, or on state != ACTIVE.
REQ-029 Counter reaching TIMEOUT_CYCLES-1 SHALL set active_port <= DEFAULT_PORT, pulse switched, stay ACTIVE; counter width = clog2(TIMEOUT_CYCLES).
REQ-030 Request and timeout on same cycle: request wins.
REQ-031 Request from port whose index = active_port during BLOCK SHALL be ignored.

Reset
REQ-032 On por: state ACTIVE, active_port = DEFAULT_PORT, switched = 0, pending = 0, counter = 0, synchronizers and edge history = 1 (idle).
REQ-033 por mid-BLOCK or mid-transaction SHALL return to reset state next edge, no pending switch retained.

Structure
REQ-034 State enum and port-index width constant SHALL reside in shared package mcu_spi_pkg.
REQ-035 Synchronizer SHALL be sub-module sync_bit (parameter STAGES, reset value 1), instantiated per port.

Verification
REQ-036 Reset, NUM_PORTS=2: active_port=0, mcu_csn follows port_csn[0], switched=0.
REQ-037 Port1 csn low while port0 idle: switched pulses once, active_port=1, mcu_csn=1 until port1 csn high, then follows port1.
REQ-038 Port1 csn low during port0 transfer: active_port stays 0 until port0 csn high, then switches; no port0 csn glitch.
REQ-039 STICKY=1 after switch to 1: port0 csn pulses -> no switch; STICKY=0, TIMEOUT_CYCLES=16: port1 idle 16 cycles -> active_port=0, switched pulse.
REQ-040 NUM_PORTS=4, ports 2 and 3 fall same cycle: active_port=2; por asserted in BLOCK -> active_port=DEFAULT_PORT, ACTIVE next cycle.

Source files
------------

// File: rtl/mcu_spi_pkg.sv
// Shared types and constants for the MCU SPI multiplexer.
package mcu_spi_pkg;

    // Width of a port index; covers up to MAX_PORTS sources.
    localparam int PORT_W    = 2;
    localparam int MAX_PORTS = 4;

    // Arbiter state: ACTIVE passes the selected port through, while BLOCK
    // holds core csn high until the new owner goes idle.
    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_BLOCK  = 1'b1
    } state_e;

    // Index of the lowest set bit (0 when none set); lowest index wins arbitration.
    function automatic logic [PORT_W-1:0] lowest_set(input logic [MAX_PORTS-1:0] v);
        logic [PORT_W-1:0] idx;
        idx = '0;
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            if (v[i]) idx = PORT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mcu_spi_mux_sync_bit.sv
// Multi-flop synchronizer for one asynchronous bit; resets to 1 (idle csn).
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through STAGES flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mcu_spi_mux.sv
// Arbitrates several MCU SPI masters onto one core SPI slave. A port requests
// ownership with a csn falling edge; the switch only happens once the current
// owner is idle, and the new owner's first transaction is blanked so the core
// never sees a partial frame. Optionally reverts to DEFAULT_PORT after idling.
module mcu_spi_mux
    import mcu_spi_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int DEFAULT_PORT   = 0,
    parameter int STICKY         = 1,
    parameter int TIMEOUT_CYCLES = 32000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clk32,
    input  logic                 por,
    input  logic [NUM_PORTS-1:0] port_sclk,
    input  logic [NUM_PORTS-1:0] port_csn,
    input  logic [NUM_PORTS-1:0] port_mosi,
    output logic [NUM_PORTS-1:0] port_miso,
    output logic [NUM_PORTS-1:0] port_intn,
    output logic                 mcu_sclk,
    output logic                 mcu_csn,
    output logic                 mcu_mosi,
    input  logic                 mcu_miso,
    input  logic                 mcu_intn,
    output logic [PORT_W-1:0]    active_port,
    output logic                 switched,
    output state_e               dbg_state
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PORT_W-1:0] DEF_IDX  = PORT_W'(DEFAULT_PORT);

    logic [NUM_PORTS-1:0] csn_sync;
    logic [NUM_PORTS-1:0] csn_prev_q;
    logic [NUM_PORTS-1:0] pending_q;
    logic [NUM_PORTS-1:0] req_d;
    logic [NUM_PORTS-1:0] pending_d;
    logic [MAX_PORTS-1:0] pending_pad;
    logic [CNT_W-1:0]     idle_cnt_q;
    logic [PORT_W-1:0]    active_q;
    logic [PORT_W-1:0]    winner;
    state_e               state_q;
    logic                 switched_q;
    logic                 act_csn_sync;
    logic                 raw_csn;
    logic                 raw_sclk;
    logic                 raw_mosi;
    logic                 accept_req;
    logic                 do_switch;
    logic                 idle_en;
    logic                 do_revert;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_sync
        sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
            .clk_i (clk32),
            .rst_i (por),
            .d_i   (port_csn[i]),
            .q_o   (csn_sync[i])
        );
    end

    // Previous-cycle copy of the synchronized csn for falling-edge detection.
    always_ff @(posedge clk32) begin
        if (por) begin
            csn_prev_q <= '1;
        end else begin
            csn_prev_q <= csn_sync;
        end
    end

    // Select the active port's signals and decide request/switch/revert.
    always_comb begin
        act_csn_sync = 1'b1;
        raw_csn      = 1'b1;
        raw_sclk     = 1'b0;
        raw_mosi     = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (active_q == PORT_W'(i)) begin
                act_csn_sync = csn_sync[i];
                raw_csn      = port_csn[i];
                raw_sclk     = port_sclk[i];
                raw_mosi     = port_mosi[i];
            end
        end
        // A sticky mux stops listening once it has left the default port.
        accept_req = (STICKY == 0) || (active_q == DEF_IDX);
        req_d      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (accept_req && csn_prev_q[i] && !csn_sync[i] && (active_q != PORT_W'(i))) begin
                req_d[i] = 1'b1;
            end
        end
        pending_d   = pending_q | req_d;
        pending_pad = MAX_PORTS'(pending_q);
        winner      = lowest_set(pending_pad);
        do_switch   = (state_q == ST_ACTIVE) && (|pending_q) && act_csn_sync;
        idle_en     = (STICKY == 0) && (state_q == ST_ACTIVE) && (active_q != DEF_IDX) && act_csn_sync;
        do_revert   = idle_en && (idle_cnt_q == CNT_LAST) && !do_switch;
    end

    // Arbiter FSM with registered selection, pulse, pending set and idle counter.
    always_ff @(posedge clk32) begin
        if (por) begin
            state_q    <= ST_ACTIVE;
            active_q   <= DEF_IDX;
            switched_q <= 1'b0;
            pending_q  <= '0;
            idle_cnt_q <= '0;
        end else begin
            switched_q <= 1'b0;
            pending_q  <= pending_d;
            case (state_q)
                ST_ACTIVE: begin
                    if (do_switch) begin
                        state_q    <= ST_BLOCK;
                        active_q   <= winner;
                        switched_q <= 1'b1;
                        pending_q  <= '0;
                    end else if (do_revert) begin
                        active_q   <= DEF_IDX;
                        switched_q <= 1'b1;
                    end
                end
                ST_BLOCK: begin
                    if (act_csn_sync) state_q <= ST_ACTIVE;
                end
                default: state_q <= ST_ACTIVE;
            endcase
            if (idle_en && !do_switch && !do_revert) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end else begin
                idle_cnt_q <= '0;
            end
        end
    end

    assign mcu_sclk    = raw_sclk;
    assign mcu_mosi    = raw_mosi;
    assign mcu_csn     = (state_q == ST_BLOCK) ? 1'b1 : raw_csn;
    assign port_miso   = {NUM_PORTS{mcu_miso}};
    assign port_intn   = {NUM_PORTS{mcu_intn}};
    assign active_port = active_q;
    assign switched    = switched_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mcu_spi_mux.sv
// Bench for mcu_spi_mux: three instances cover the sticky 2-port default,
// a non-sticky 2-port mux with a short timeout, and a 4-port mux.
module tb_mcu_spi_mux;
    import mcu_spi_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk32 = 1'b0;
    logic por   = 1'b1;
    always #5 clk32 = ~clk32;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- DUT A: 2 ports, sticky ----------------
    logic [1:0] a_sclk, a_csn, a_mosi, a_miso_o, a_intn_o, a_act;
    logic a_miso, a_intn, a_msclk, a_mcsn, a_mmosi, a_sw;
    state_e a_st;

    mcu_spi_mux #(.NUM_PORTS(2), .DEFAULT_PORT(0), .STICKY(1)) dut_a (
        .clk32(clk32), .por(por),
        .port_sclk(a_sclk), .port_csn(a_csn), .port_mosi(a_mosi),
        .port_miso(a_miso_o), .port_intn(a_intn_o),
        .mcu_sclk(a_msclk), .mcu_csn(a_mcsn), .mcu_mosi(a_mmosi),
        .mcu_miso(a_miso), .mcu_intn(a_intn),
        .active_port(a_act), .switched(a_sw), .dbg_state(a_st)
    );

    // ---------------- DUT B: 2 ports, non-sticky, timeout 16 ----------------
    logic [1:0] b_sclk, b_csn, b_mosi, b_miso_o, b_intn_o, b_act;
    logic b_msclk, b_mcsn, b_mmosi, b_sw;
    state_e b_st;

    mcu_spi_mux #(.NUM_PORTS(2), .DEFAULT_PORT(0), .STICKY(0), .TIMEOUT_CYCLES(16)) dut_b (
        .clk32(clk32), .por(por),
        .port_sclk(b_sclk), .port_csn(b_csn), .port_mosi(b_mosi),
        .port_miso(b_miso_o), .port_intn(b_intn_o),
        .mcu_sclk(b_msclk), .mcu_csn(b_mcsn), .mcu_mosi(b_mmosi),
        .mcu_miso(1'b0), .mcu_intn(1'b1),
        .active_port(b_act), .switched(b_sw), .dbg_state(b_st)
    );

    // ---------------- DUT C: 4 ports, sticky ----------------
    logic [3:0] c_sclk, c_csn, c_mosi, c_miso_o, c_intn_o;
    logic [1:0] c_act;
    logic c_msclk, c_mcsn, c_mmosi, c_sw;
    state_e c_st;

    mcu_spi_mux #(.NUM_PORTS(4), .DEFAULT_PORT(0), .STICKY(1)) dut_c (
        .clk32(clk32), .por(por),
        .port_sclk(c_sclk), .port_csn(c_csn), .port_mosi(c_mosi),
        .port_miso(c_miso_o), .port_intn(c_intn_o),
        .mcu_sclk(c_msclk), .mcu_csn(c_mcsn), .mcu_mosi(c_mmosi),
        .mcu_miso(1'b1), .mcu_intn(1'b0),
        .active_port(c_act), .switched(c_sw), .dbg_state(c_st)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [5:0] exp_q[$];

    typedef struct {
        int         sel;
        logic [1:0] sclk;
        logic [1:0] mosi;
        logic       miso;
        logic       intn;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk32);
        #1;
    endtask

    // Apply table rows lo..hi-1 to DUT A, score combinational mux/broadcast outputs.
    task automatic run_vecs(input int lo, input int hi);
        logic [5:0] exp;
        for (int i = lo; i < hi; i++) begin
            a_sclk = tbl[i].sclk;
            a_mosi = tbl[i].mosi;
            a_miso = tbl[i].miso;
            a_intn = tbl[i].intn;
            exp_q.push_back(tbl[i].exp);
            #1;
            exp = exp_q.pop_front();
            check($sformatf("vec%0d", i), 8'({a_msclk, a_mmosi, a_miso_o, a_intn_o}), 8'(exp));
            step();
        end
    endtask

    int   cnt;
    int   n;
    logic seen;

    initial begin
        // Table: rows 0..5 scored with port 0 selected, rows 6..11 with port 1.
        for (int i = 0; i < 12; i++) begin
            tbl[i].sel  = (i < 6) ? 0 : 1;
            tbl[i].sclk = 2'(i % 4);
            tbl[i].mosi = 2'($urandom_range(0, 3));
            tbl[i].miso = 1'($urandom_range(0, 1));
            tbl[i].intn = 1'(i % 2);
            tbl[i].exp  = {tbl[i].sclk[tbl[i].sel], tbl[i].mosi[tbl[i].sel],
                           {2{tbl[i].miso}}, {2{tbl[i].intn}}};
        end

        a_sclk = '0; a_csn = '1; a_mosi = '0; a_miso = 1'b0; a_intn = 1'b1;
        b_sclk = '0; b_csn = '1; b_mosi = '0;
        c_sclk = '0; c_csn = '1; c_mosi = '0;
        por = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_a_act", 8'(a_act), 8'd0);
        check("rst_a_sw", 8'(a_sw), 8'd0);
        check("rst_a_state", 8'(a_st), 8'(ST_ACTIVE));
        check("rst_c_act", 8'(c_act), 8'd0);
        por = 1'b0;
        step();
        a_csn[0] = 1'b0; #1;
        check("rst_mcsn_follow_lo", 8'(a_mcsn), 8'd0);
        a_csn[0] = 1'b1; #1;
        check("rst_mcsn_follow_hi", 8'(a_mcsn), 8'd1);
        step();

        run_vecs(0, 6);

        // Port 1 requests during a port 0 transfer: no switch, no csn glitch.
        a_csn[0] = 1'b0;
        repeat (4) step();
        a_csn[1] = 1'b0;
        cnt = 0; n = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (a_mcsn !== 1'b0) cnt++;
            if (a_act !== 2'd0) n++;
        end
        check("busy_no_glitch", 8'(cnt), 8'd0);
        check("busy_no_switch", 8'(n), 8'd0);
        a_csn[0] = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (a_sw) cnt++;
        end
        check("busy_switch_pulses", 8'(cnt), 8'd1);
        check("busy_act_after", 8'(a_act), 8'd1);
        check("busy_block_state", 8'(a_st), 8'(ST_BLOCK));
        check("busy_block_mcsn", 8'(a_mcsn), 8'd1);

        run_vecs(6, 12);

        a_csn[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (a_st == ST_ACTIVE) begin seen = 1'b1; break; end
        end
        check("a_block_exit", 8'(seen), 8'd1);
        a_csn[1] = 1'b0; #1;
        check("a_follow_p1_lo", 8'(a_mcsn), 8'd0);
        a_csn[1] = 1'b1; #1;
        check("a_follow_p1_hi", 8'(a_mcsn), 8'd1);
        step();

        // Sticky: port 0 request after switching away is ignored.
        a_csn[0] = 1'b0;
        repeat (3) step();
        a_csn[0] = 1'b1;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (a_sw) cnt++;
        end
        check("sticky_no_pulse", 8'(cnt), 8'd0);
        check("sticky_act", 8'(a_act), 8'd1);

        // Non-sticky: port 1 takes over idle port 0, then times out back.
        b_csn[1] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (b_sw) cnt++;
        end
        check("b_take_pulses", 8'(cnt), 8'd1);
        check("b_take_act", 8'(b_act), 8'd1);
        check("b_block_mcsn", 8'(b_mcsn), 8'd1);
        b_csn[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (b_st == ST_ACTIVE) begin seen = 1'b1; break; end
        end
        check("b_block_exit", 8'(seen), 8'd1);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            n++;
            if (b_sw) break;
        end
        check("b_timeout_cycles", 8'(n), 8'd16);
        check("b_timeout_act", 8'(b_act), 8'd0);
        check("b_timeout_state", 8'(b_st), 8'(ST_ACTIVE));
        b_csn[0] = 1'b0; #1;
        check("b_follow_p0", 8'(b_mcsn), 8'd0);
        b_csn[0] = 1'b1;
        step();

        // Non-sticky: port 0 can take ownership back before the timeout.
        b_csn[1] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (b_sw) begin seen = 1'b1; break; end
        end
        check("b_retake_seen", 8'(seen), 8'd1);
        b_csn[1] = 1'b1;
        repeat (4) step();
        b_csn[0] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (b_sw) begin seen = 1'b1; break; end
        end
        check("b_takeback_seen", 8'(seen), 8'd1);
        check("b_takeback_act", 8'(b_act), 8'd0);
        b_csn[0] = 1'b1;
        repeat (4) step();

        // Four ports: 2 and 3 request together, lowest index wins.
        c_csn[2] = 1'b0;
        c_csn[3] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (c_sw) begin seen = 1'b1; break; end
        end
        check("c_switch_seen", 8'(seen), 8'd1);
        check("c_winner", 8'(c_act), 8'd2);
        check("c_block_state", 8'(c_st), 8'(ST_BLOCK));
        c_sclk = 4'b0100; #1;
        check("c_sclk_p2_hi", 8'(c_msclk), 8'd1);
        c_sclk = 4'b1011; #1;
        check("c_sclk_p2_lo", 8'(c_msclk), 8'd0);
        c_mosi = 4'b0100; #1;
        check("c_mosi_p2", 8'(c_mmosi), 8'd1);
        check("c_miso_bcast", 8'(c_miso_o), 8'hf);

        // Reset in BLOCK returns to default port, ACTIVE, next edge.
        por = 1'b1;
        c_csn = '1;
        step();
        check("c_por_act", 8'(c_act), 8'd0);
        check("c_por_state", 8'(c_st), 8'(ST_ACTIVE));
        check("c_por_sw", 8'(c_sw), 8'd0);
        por = 1'b0;
        step();

        // Reset drops a pending request held behind a busy port 0.
        c_csn[0] = 1'b0;
        repeat (2) step();
        c_csn[1] = 1'b0;
        repeat (8) step();
        check("c_pending_held", 8'(c_act), 8'd0);
        por = 1'b1;
        c_csn = '1;
        step();
        por = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (c_sw) cnt++;
        end
        check("c_pending_dropped", 8'(cnt), 8'd0);
        check("c_pending_act", 8'(c_act), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
